// File: rtl/sync_fifo_pop_stream_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_pop_stream_if
// Bundles the two sides of the pop-stream adapter into one interface:
//   - the sync_fifo pop port (fifo_re out, fifo_rd / fifo_empt / fifo_fsh in)
//   - the outgoing valid/ready stream (m_vld, m_data, m_last out, m_rdy in)
// The master modport is the adapter's view. The slave modport is the view of
// the surrounding logic, which owns the FIFO and the downstream consumer.
// ---------------------------------------------------------------------------
interface sync_fifo_pop_stream_if #(
    parameter int FIFO_W = 32
);
    logic              fifo_re;
    logic [FIFO_W-1:0] fifo_rd;
    logic              fifo_empt;
    logic              fifo_fsh;
    logic              m_vld;
    logic              m_rdy;
    logic [FIFO_W-1:0] m_data;
    logic              m_last;

    modport master (
        output fifo_re,
        input  fifo_rd,
        input  fifo_empt,
        input  fifo_fsh,
        output m_vld,
        input  m_rdy,
        output m_data,
        output m_last
    );

    modport slave (
        input  fifo_re,
        output fifo_rd,
        output fifo_empt,
        output fifo_fsh,
        input  m_vld,
        output m_rdy,
        input  m_data,
        input  m_last
    );
endinterface

// File: rtl/sync_fifo_pop_stream.sv
// ---------------------------------------------------------------------------
// sync_fifo_pop_stream
// Pop-side adapter for sync_fifo. It pops the FIFO and re-presents the words
// as a valid/ready stream through a 2-entry skid buffer. It hides the FIFO
// read latency (FIFO_DLY = 0 or 1) and flags every PKT_LEN-th accepted beat
// with m_last. With m_rdy held high it sustains one beat per cycle.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous reset, active-high
//   bus   - sync_fifo_pop_stream_if.master
//             fifo_re   out  pop request to the FIFO
//             fifo_rd   in   FIFO read data
//             fifo_empt in   FIFO empty flag
//             fifo_fsh  in   flush; the same signal that flushes the FIFO
//             m_vld     out  output beat valid
//             m_rdy     in   downstream ready
//             m_data    out  output beat data (head of the skid buffer)
//             m_last    out  last beat of a packet
//   busy  - out: buffer non-empty or a pop still in flight
// ---------------------------------------------------------------------------
module sync_fifo_pop_stream #(
    parameter int FIFO_W   = 32,
    parameter int FIFO_DLY = 0,
    parameter int PKT_LEN  = 4,
    parameter int CNT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    sync_fifo_pop_stream_if.master bus,
    output logic                  busy
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN - 1);

    logic [1:0]        buf_cnt_q, buf_cnt_d;
    logic              inflight_q, inflight_d;
    logic [CNT_W-1:0]  bcnt_q, bcnt_d;
    logic [FIFO_W-1:0] ent0_q, ent0_d;
    logic [FIFO_W-1:0] ent1_q, ent1_d;

    logic              vld;
    logic              deq;
    logic              pop;
    logic              capture;
    logic [2:0]        occ;

    // Occupancy seen by the pop decision counts words already buffered, plus
    // the word still coming back from the FIFO, minus the beat leaving this
    // cycle. Crediting the leaving beat is what allows back-to-back pops at
    // full rate. It creates the m_rdy -> fifo_re combinational path on purpose.
    assign vld     = (buf_cnt_q != 2'd0);
    assign deq     = vld & bus.m_rdy;
    assign occ     = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, deq};
    assign pop     = ~bus.fifo_empt & ~bus.fifo_fsh & ~rst & (occ < 3'd2);
    assign capture = (FIFO_DLY == 0) ? pop : inflight_q;

    assign bus.fifo_re = pop;
    assign bus.m_vld   = vld;
    assign bus.m_data  = ent0_q;
    assign bus.m_last  = vld & (bcnt_q == LAST_BEAT);
    assign busy        = vld | inflight_q;

    // Next-state logic for the skid buffer, the in-flight flag and the beat
    // counter. Entry 0 is always the head. On a dequeue the tail slides
    // forward. A capture fills the first free slot once any dequeue has been
    // taken into account, so a capture and a dequeue in the same cycle keep
    // the count unchanged and keep the words in order. Flush wins over
    // everything. This drops a word whose pop was issued one cycle earlier,
    // because the in-flight flag is cleared.
    always_comb begin
        buf_cnt_d  = buf_cnt_q;
        ent0_d     = ent0_q;
        ent1_d     = ent1_q;
        bcnt_d     = bcnt_q;
        inflight_d = (FIFO_DLY == 1) ? pop : 1'b0;

        if (deq) begin
            bcnt_d = (bcnt_q == LAST_BEAT) ? '0 : bcnt_q + CNT_W'(1);
        end

        case ({capture, deq})
            2'b10: begin
                if (buf_cnt_q == 2'd0) begin
                    ent0_d = bus.fifo_rd;
                end else begin
                    ent1_d = bus.fifo_rd;
                end
                buf_cnt_d = buf_cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d    = ent1_q;
                ent1_d    = '0;
                buf_cnt_d = buf_cnt_q - 2'd1;
            end
            2'b11: begin
                if (buf_cnt_q == 2'd1) begin
                    ent0_d = bus.fifo_rd;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = bus.fifo_rd;
                end
            end
            default: begin
            end
        endcase

        if (bus.fifo_fsh) begin
            buf_cnt_d  = 2'd0;
            inflight_d = 1'b0;
            bcnt_d     = '0;
            ent0_d     = '0;
            ent1_d     = '0;
        end
    end

    // State registers. Reset clears everything asynchronously, including a
    // pending in-flight word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_cnt_q  <= 2'd0;
            inflight_q <= 1'b0;
            bcnt_q     <= '0;
            ent0_q     <= '0;
            ent1_q     <= '0;
        end else begin
            buf_cnt_q  <= buf_cnt_d;
            inflight_q <= inflight_d;
            bcnt_q     <= bcnt_d;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
        end
    end

    // The pop rule guarantees that the buffer never receives a word it has
    // no room for.
    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(capture && !deq && !bus.fifo_fsh && (buf_cnt_q == 2'd2)));

endmodule

// File: tb/tb_sync_fifo_pop_stream.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_pop_stream
// Self-checking bench for both read-latency variants of the pop-stream
// adapter. The FIFO is modelled as a queue. The expected stream is a
// queue-based reference: a list of buffered words, an optional word in
// flight, and a count of accepted beats.
// ---------------------------------------------------------------------------
module tb_sync_fifo_pop_stream;

    localparam int W   = 32;
    localparam int PKT = 4;

    logic clk = 1'b0;
    logic rst;
    logic busy0, busy1;

    int errors = 0;
    int checks = 0;
    int sel    = 0;
    int dly    = 0;

    // Reference state
    logic [W-1:0] src[$];
    logic [W-1:0] exp_out[$];
    logic [W-1:0] mbuf[$];
    bit           infl;
    logic [W-1:0] rd1;
    int           beats;

    // Per-phase statistics gathered from the DUT
    int           cyc, pops, first_re, last_re, first_vld, dut_beats, dut_lasts;
    logic [W-1:0] first_data, last_data;
    logic         last_busy, last_vld;

    always #5 clk = ~clk;

    sync_fifo_pop_stream_if #(.FIFO_W(W)) if0 ();
    sync_fifo_pop_stream_if #(.FIFO_W(W)) if1 ();

    sync_fifo_pop_stream #(.FIFO_W(W), .FIFO_DLY(0), .PKT_LEN(PKT)) dut0 (
        .clk  (clk),
        .rst  (rst),
        .bus  (if0),
        .busy (busy0)
    );

    sync_fifo_pop_stream #(.FIFO_W(W), .FIFO_DLY(1), .PKT_LEN(PKT)) dut1 (
        .clk  (clk),
        .rst  (rst),
        .bus  (if1),
        .busy (busy1)
    );

    // Counts one comparison and reports it if the values differ
    task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s (dly=%0d cyc=%0d) got=0x%0h expected=0x%0h", tag, dly, cyc, got, want);
        end
    endtask

    task automatic driveIn(input logic rdy, input logic fsh, input logic empt, input logic [W-1:0] rd);
        if (sel == 0) begin
            if0.m_rdy = rdy; if0.fifo_fsh = fsh; if0.fifo_empt = empt; if0.fifo_rd = rd;
        end else begin
            if1.m_rdy = rdy; if1.fifo_fsh = fsh; if1.fifo_empt = empt; if1.fifo_rd = rd;
        end
    endtask

    task automatic sampleOut(output logic re, output logic vld, output logic last,
                             output logic bsy, output logic [W-1:0] data);
        if (sel == 0) begin
            re = if0.fifo_re; vld = if0.m_vld; last = if0.m_last; bsy = busy0; data = if0.m_data;
        end else begin
            re = if1.fifo_re; vld = if1.m_vld; last = if1.m_last; bsy = busy1; data = if1.m_data;
        end
    endtask

    task automatic idleAll();
        if0.m_rdy = 1'b0; if0.fifo_fsh = 1'b0; if0.fifo_empt = 1'b1; if0.fifo_rd = '0;
        if1.m_rdy = 1'b0; if1.fifo_fsh = 1'b0; if1.fifo_empt = 1'b1; if1.fifo_rd = '0;
    endtask

    task automatic clearModel();
        src.delete(); exp_out.delete(); mbuf.delete();
        infl = 1'b0; rd1 = '0; beats = 0;
    endtask

    task automatic resetStats();
        pops = 0; first_re = -1; last_re = -1; first_vld = -1;
        dut_beats = 0; dut_lasts = 0; first_data = '0; last_data = '0;
        last_busy = 1'b0; last_vld = 1'b0;
    endtask

    task automatic pushWord(input logic [W-1:0] w);
        src.push_back(w);
        exp_out.push_back(w);
    endtask

    // Holds reset over two edges, then selects which instance is driven
    task automatic doReset(input int which);
        rst = 1'b1;
        idleAll();
        sel = which;
        dly = which;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        clearModel();
        resetStats();
        cyc = 0;
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle against the
    // reference, then advance the FIFO model and the reference after the edge
    task automatic applyStimulus(input logic rdy, input logic fsh);
        logic         re, vld, last, bsy;
        logic [W-1:0] data, head, w;
        bit           exp_vld, exp_deq, exp_re;
        int           occ;
        head = (src.size() != 0) ? src[0] : '0;
        driveIn(rdy, fsh, src.size() == 0, (dly == 0) ? head : rd1);
        @(negedge clk);
        sampleOut(re, vld, last, bsy, data);
        exp_vld = (mbuf.size() != 0);
        exp_deq = exp_vld && rdy;
        occ     = mbuf.size() + int'(infl) - int'(exp_deq);
        exp_re  = (src.size() != 0) && !fsh && (occ < 2);
        checkOutput("m_vld", vld, exp_vld);
        checkOutput("fifo_re", re, exp_re);
        checkOutput("busy", bsy, (mbuf.size() != 0) || infl);
        if (exp_vld) begin
            checkOutput("m_data", data, mbuf[0]);
            checkOutput("m_last", last, ((beats % PKT) == PKT - 1));
        end else begin
            checkOutput("m_last_idle", last, 1'b0);
        end
        if (re) begin
            pops++;
            if (first_re < 0) first_re = cyc;
            last_re = cyc;
        end
        if (vld && first_vld < 0) first_vld = cyc;
        if (vld && rdy) begin
            if (dut_beats == 0) first_data = data;
            dut_beats++;
            if (last) dut_lasts++;
        end
        if (exp_deq) begin
            w = (exp_out.size() != 0) ? exp_out.pop_front() : ~data;
            checkOutput("sb_order", data, w);
            beats++;
        end
        last_data = data;
        last_busy = bsy;
        last_vld  = vld;
        @(posedge clk);
        #1;
        cyc++;
        if (exp_deq) void'(mbuf.pop_front());
        if (dly == 0) begin
            if (re && src.size() != 0) mbuf.push_back(src.pop_front());
        end else begin
            if (infl) mbuf.push_back(rd1);
            if (re && src.size() != 0) begin
                rd1  = src.pop_front();
                infl = 1'b1;
            end else begin
                infl = 1'b0;
            end
        end
        if (fsh) begin
            mbuf.delete(); src.delete(); exp_out.delete();
            infl  = 1'b0;
            beats = 0;
        end
    endtask

    initial begin
        logic         re, vld, last, bsy;
        logic [W-1:0] data;
        rst = 1'b1;
        idleAll();
        cyc = 0;
        // Reset state, with the FIFO non-empty and m_rdy high
        if0.fifo_empt = 1'b0; if0.m_rdy = 1'b1;
        if1.fifo_empt = 1'b0; if1.m_rdy = 1'b1;
        #3;
        for (int s = 0; s < 2; s++) begin
            sel = s; dly = s;
            sampleOut(re, vld, last, bsy, data);
            checkOutput("rst_fifo_re", re, 1'b0);
            checkOutput("rst_m_vld", vld, 1'b0);
            checkOutput("rst_m_last", last, 1'b0);
            checkOutput("rst_busy", bsy, 1'b0);
            checkOutput("rst_m_data", data, '0);
        end

        for (int d = 0; d < 2; d++) begin
            $display("[TB] latency variant FIFO_DLY=%0d", d);

            // Preloaded streaming at full rate
            doReset(d);
            for (int i = 0; i < 8; i++) pushWord(32'h10 + i);
            for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b0);
            checkOutput("stream_latency", first_vld - first_re, d + 1);
            checkOutput("stream_pops", pops, 8);
            checkOutput("stream_re_run", last_re - first_re, 7);
            checkOutput("stream_beats", dut_beats, 8);
            checkOutput("stream_lasts", dut_lasts, 2);
            checkOutput("stream_idle_busy", last_busy, 1'b0);

            // Backpressure, then release
            doReset(d);
            for (int i = 0; i < 8; i++) pushWord(32'h10 + i);
            for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0);
            checkOutput("bp_pops", pops, 2);
            checkOutput("bp_hold_data", last_data, 32'h10);
            checkOutput("bp_hold_vld", last_vld, 1'b1);
            for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b0);
            checkOutput("bp_first", first_data, 32'h10);
            checkOutput("bp_beats", dut_beats, 8);

            // Ready toggling over 16 random beats
            doReset(d);
            for (int i = 0; i < 16; i++) pushWord($urandom);
            for (int i = 0; i < 48; i++) applyStimulus((i % 2) == 0, 1'b0);
            checkOutput("tog_beats", dut_beats, 16);
            checkOutput("tog_lasts", dut_lasts, 4);

            // Flush while streaming with a pop in flight
            doReset(d);
            for (int i = 0; i < 8; i++) pushWord(32'h20 + i);
            for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
            applyStimulus(1'b0, 1'b1);
            applyStimulus(1'b0, 1'b0);
            checkOutput("fsh_vld", last_vld, 1'b0);
            checkOutput("fsh_busy", last_busy, 1'b0);
            dut_beats = 0; dut_lasts = 0;
            for (int i = 0; i < 5; i++) pushWord(32'hAA + i);
            for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0);
            checkOutput("fsh_first", first_data, 32'hAA);
            checkOutput("fsh_beats", dut_beats, 5);
            checkOutput("fsh_lasts", dut_lasts, 1);

            // Asynchronous reset mid-stream
            doReset(d);
            for (int i = 0; i < 8; i++) pushWord(32'h30 + i);
            for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
            driveIn(1'b1, 1'b0, 1'b0, (d == 0) ? src[0] : rd1);
            #2 rst = 1'b1;
            #1;
            sampleOut(re, vld, last, bsy, data);
            checkOutput("mrst_fifo_re", re, 1'b0);
            checkOutput("mrst_m_vld", vld, 1'b0);
            checkOutput("mrst_m_last", last, 1'b0);
            checkOutput("mrst_busy", bsy, 1'b0);
            checkOutput("mrst_m_data", data, '0);
            clearModel();
            resetStats();
            @(posedge clk);
            #1 rst = 1'b0;
            for (int i = 0; i < 8; i++) pushWord(32'h50 + i);
            for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b0);
            checkOutput("mrst_beats", dut_beats, 8);
            checkOutput("mrst_first", first_data, 32'h50);

            // Random traffic with random ready and occasional flush
            doReset(d);
            for (int i = 0; i < 400; i++) begin
                if (($urandom % 2) == 0 && src.size() < 16) pushWord($urandom);
                applyStimulus(($urandom % 4) != 0, ($urandom % 50) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
